// File: rtl/tpm_cmd_sequencer.sv
// Command sequencer between the TPM IO front end and the execution engine:
// arbitrates locality requests, starts the engine, watches it for timeout and holds the response.
module tpm_cmd_sequencer #(
    parameter int          NUM_LOC        = 5,
    parameter int          ARB_MODE       = 0,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [31:0] TIMEOUT_RC     = 32'h0000_0909,
    parameter int          CW             = 20
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_LOC-1:0]    req_valid,
    input  logic [32*NUM_LOC-1:0] req_code,
    output logic [NUM_LOC-1:0]    grant,
    output logic                  exec_start,
    output logic [31:0]           exec_code,
    output logic [7:0]            exec_locality,
    input  logic                  eng_done,
    input  logic [31:0]           eng_rc,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_code,
    output logic [7:0]            rsp_locality,
    input  logic                  rsp_ack,
    output logic                  busy,
    output logic                  timeout_flag,
    output logic [15:0]           cmd_count
);

    localparam int LW = (NUM_LOC > 1) ? $clog2(NUM_LOC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [LW-1:0]        rr_q, rr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_LOC-1:0]   grant_q, grant_d;
    logic                 exec_start_q, exec_start_d;
    logic [31:0]          exec_code_q, exec_code_d;
    logic [7:0]           exec_loc_q, exec_loc_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_code_q, rsp_code_d;
    logic [7:0]           rsp_loc_q, rsp_loc_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic [15:0]          cmd_count_q, cmd_count_d;

    logic [LW-1:0]        sel_s;
    logic                 found_s;
    logic                 hit_s;
    logic [31:0]          code_arr_s [NUM_LOC];

    for (genvar g = 0; g < NUM_LOC; g++) begin : g_code
        assign code_arr_s[g] = req_code[32*g +: 32];
    end

    // Arbiter: pick the channel to grant from the current request vector.
    always_comb begin : arb_sel
        int idx;
        sel_s   = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx     = 0;
        if (ARB_MODE == 1) begin
            // Scan upward from the pointer, wrapping; the first hit is kept.
            for (int k = 0; k < NUM_LOC; k++) begin
                idx = int'(rr_q) + k;
                idx = (idx >= NUM_LOC) ? (idx - NUM_LOC) : idx;
                hit_s   = !found_s && req_valid[LW'(idx)];
                sel_s   = hit_s ? LW'(idx) : sel_s;
                found_s = found_s | hit_s;
            end
        end else begin
            for (int i = 0; i < NUM_LOC; i++) begin
                sel_s   = req_valid[LW'(i)] ? LW'(i) : sel_s;
                found_s = found_s | req_valid[LW'(i)];
            end
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        grant_d      = '0;
        exec_start_d = 1'b0;
        exec_code_d  = exec_code_q;
        exec_loc_d   = exec_loc_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_code_d   = rsp_code_q;
        rsp_loc_d    = rsp_loc_q;
        timeout_d    = timeout_q;
        cmd_count_d  = cmd_count_q;

        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d      = ST_START;
                    grant_d      = NUM_LOC'(1) << sel_s;
                    exec_start_d = 1'b1;
                    exec_code_d  = code_arr_s[sel_s];
                    exec_loc_d   = {{(8-LW){1'b0}}, sel_s};
                    if (ARB_MODE == 1) begin
                        rr_d = (sel_s == LW'(NUM_LOC-1)) ? LW'(0) : (sel_s + LW'(1));
                    end else begin
                        rr_d = rr_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // A completion in the final watchdog cycle still counts as done.
                if (eng_done) begin
                    rsp_code_d  = eng_rc;
                    timeout_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_loc_d   = exec_loc_q;
                    state_d     = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
                    rsp_code_d  = TIMEOUT_RC;
                    timeout_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_loc_d   = exec_loc_q;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ack) begin
                    cmd_count_d = cmd_count_q + 16'd1;
                    rsp_valid_d = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            cnt_q        <= '0;
            grant_q      <= '0;
            exec_start_q <= 1'b0;
            exec_code_q  <= 32'd0;
            exec_loc_q   <= 8'd0;
            rsp_valid_q  <= 1'b0;
            rsp_code_q   <= 32'd0;
            rsp_loc_q    <= 8'd0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cmd_count_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            exec_start_q <= exec_start_d;
            exec_code_q  <= exec_code_d;
            exec_loc_q   <= exec_loc_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_code_q   <= rsp_code_d;
            rsp_loc_q    <= rsp_loc_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            cmd_count_q  <= cmd_count_d;
        end
    end

    assign grant         = grant_q;
    assign exec_start    = exec_start_q;
    assign exec_code     = exec_code_q;
    assign exec_locality = exec_loc_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_code      = rsp_code_q;
    assign rsp_locality  = rsp_loc_q;
    assign busy          = busy_q;
    assign timeout_flag  = timeout_q;
    assign cmd_count     = cmd_count_q;

endmodule

// File: tb/tb_tpm_cmd_sequencer.sv
// Directed bench: instance a is fixed-priority, instance b round-robin, both with an 8-cycle watchdog.
module tb_tpm_cmd_sequencer;

    logic         clock;
    logic         reset_n;

    logic [4:0]   a_req_valid, b_req_valid;
    logic [159:0] a_req_code, b_req_code;
    logic [4:0]   a_grant, b_grant;
    logic         a_exec_start, b_exec_start;
    logic [31:0]  a_exec_code, b_exec_code;
    logic [7:0]   a_exec_locality, b_exec_locality;
    logic         a_eng_done, b_eng_done;
    logic [31:0]  a_eng_rc, b_eng_rc;
    logic         a_rsp_valid, b_rsp_valid;
    logic [31:0]  a_rsp_code, b_rsp_code;
    logic [7:0]   a_rsp_locality, b_rsp_locality;
    logic         a_rsp_ack, b_rsp_ack;
    logic         a_busy, b_busy;
    logic         a_timeout_flag, b_timeout_flag;
    logic [15:0]  a_cmd_count, b_cmd_count;

    int n_checks = 0;
    int n_errors = 0;

    tpm_cmd_sequencer #(
        .NUM_LOC(5), .ARB_MODE(0), .TIMEOUT_CYCLES(8), .TIMEOUT_RC(32'h0000_0909), .CW(4)
    ) u_fp (
        .clock(clock), .reset_n(reset_n),
        .req_valid(a_req_valid), .req_code(a_req_code), .grant(a_grant),
        .exec_start(a_exec_start), .exec_code(a_exec_code), .exec_locality(a_exec_locality),
        .eng_done(a_eng_done), .eng_rc(a_eng_rc),
        .rsp_valid(a_rsp_valid), .rsp_code(a_rsp_code), .rsp_locality(a_rsp_locality),
        .rsp_ack(a_rsp_ack), .busy(a_busy), .timeout_flag(a_timeout_flag), .cmd_count(a_cmd_count)
    );

    tpm_cmd_sequencer #(
        .NUM_LOC(5), .ARB_MODE(1), .TIMEOUT_CYCLES(8), .TIMEOUT_RC(32'h0000_0909), .CW(4)
    ) u_rr (
        .clock(clock), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_code(b_req_code), .grant(b_grant),
        .exec_start(b_exec_start), .exec_code(b_exec_code), .exec_locality(b_exec_locality),
        .eng_done(b_eng_done), .eng_rc(b_eng_rc),
        .rsp_valid(b_rsp_valid), .rsp_code(b_rsp_code), .rsp_locality(b_rsp_locality),
        .rsp_ack(b_rsp_ack), .busy(b_busy), .timeout_flag(b_timeout_flag), .cmd_count(b_cmd_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_a_start(input string tag);
        for (int i = 0; i < 20 && a_exec_start !== 1'b1; i++) tick();
        check(tag, 32'(a_exec_start), 32'd1);
    endtask

    initial begin
        int ch;
        int bad;
        reset_n = 1'b0;
        a_req_valid = 5'd0; a_req_code = 160'd0; a_eng_done = 1'b0; a_eng_rc = 32'd0; a_rsp_ack = 1'b0;
        b_req_valid = 5'd0; b_req_code = 160'd0; b_eng_done = 1'b0; b_eng_rc = 32'd0; b_rsp_ack = 1'b0;
        tick(); tick();
        check("rst_busy",      32'(a_busy), 32'd0);
        check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_grant",     32'(a_grant), 32'd0);
        check("rst_exec_code", a_exec_code, 32'd0);
        check("rst_cmd_count", 32'(a_cmd_count), 32'd0);
        check("rst_rr_busy",   32'(b_busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // Fixed priority: ch4 beats ch1
        a_req_code[32 +: 32]  = 32'h0000_0144;
        a_req_code[128 +: 32] = 32'h0000_017A;
        a_req_valid = 5'b10010;
        tick();
        check("fp_grant",      32'(a_grant), 32'h10);
        check("fp_exec_start", 32'(a_exec_start), 32'd1);
        check("fp_exec_code",  a_exec_code, 32'h17A);
        check("fp_exec_loc",   32'(a_exec_locality), 32'd4);
        check("fp_busy",       32'(a_busy), 32'd1);
        a_req_valid = 5'b00000;
        tick();
        check("fp_grant_pulse", 32'(a_grant), 32'd0);
        check("fp_start_pulse", 32'(a_exec_start), 32'd0);
        tick(); tick();
        check("fp_no_rsp_yet", 32'(a_rsp_valid), 32'd0);
        a_eng_done = 1'b1; a_eng_rc = 32'd0;
        tick();
        a_eng_done = 1'b0;
        check("fp_rsp_valid", 32'(a_rsp_valid), 32'd1);
        check("fp_rsp_code",  a_rsp_code, 32'd0);
        check("fp_rsp_loc",   32'(a_rsp_locality), 32'd4);
        check("fp_to_flag",   32'(a_timeout_flag), 32'd0);
        a_rsp_ack = 1'b1;
        tick();
        a_rsp_ack = 1'b0;
        check("fp_rsp_clear", 32'(a_rsp_valid), 32'd0);
        check("fp_count1",    32'(a_cmd_count), 32'd1);
        check("fp_idle",      32'(a_busy), 32'd0);

        // Round robin: all channels requesting, order 0,1,2,3,4,0
        for (int i = 0; i < 5; i++) b_req_code[32*i +: 32] = 32'h200 + 32'(i);
        b_req_valid = 5'b11111;
        for (int r = 0; r < 6; r++) begin
            ch = r % 5;
            for (int i = 0; i < 20 && b_exec_start !== 1'b1; i++) tick();
            check("rr_grant", 32'(b_grant), 32'(5'b00001 << ch));
            check("rr_code",  b_exec_code, 32'h200 + 32'(ch));
            tick();
            b_eng_done = 1'b1; b_eng_rc = 32'hA0 + 32'(r);
            tick();
            b_eng_done = 1'b0;
            check("rr_rsp_code", b_rsp_code, 32'hA0 + 32'(r));
            b_rsp_ack = 1'b1;
            tick();
            b_rsp_ack = 1'b0;
        end
        b_req_valid = 5'b00000;
        check("rr_count", 32'(b_cmd_count), 32'd6);

        // Timeout with no completion, then a late done that must be ignored
        a_req_code[0 +: 32] = 32'h0000_0055;
        a_req_valid = 5'b00001;
        wait_a_start("to_start");
        a_req_valid = 5'b00000;
        for (int i = 0; i < 8; i++) tick();
        check("to_not_yet", 32'(a_rsp_valid), 32'd0);
        tick();
        check("to_rsp_valid", 32'(a_rsp_valid), 32'd1);
        check("to_rsp_code",  a_rsp_code, 32'h909);
        check("to_flag",      32'(a_timeout_flag), 32'd1);
        check("to_rsp_loc",   32'(a_rsp_locality), 32'd0);
        tick(); tick();
        a_eng_done = 1'b1; a_eng_rc = 32'h0000_DEAD;
        tick();
        a_eng_done = 1'b0;
        check("late_done_code", a_rsp_code, 32'h909);
        check("late_done_flag", 32'(a_timeout_flag), 32'd1);
        a_rsp_ack = 1'b1;
        tick();
        a_rsp_ack = 1'b0;
        check("to_flag_clear", 32'(a_timeout_flag), 32'd0);
        check("to_count", 32'(a_cmd_count), 32'd2);

        // Done in the same cycle the counter reaches TIMEOUT_CYCLES-1
        a_req_valid = 5'b00001;
        wait_a_start("race_start");
        a_req_valid = 5'b00000;
        for (int i = 0; i < 8; i++) tick();
        a_eng_done = 1'b1; a_eng_rc = 32'h0000_0101;
        tick();
        a_eng_done = 1'b0;
        check("race_valid", 32'(a_rsp_valid), 32'd1);
        check("race_code",  a_rsp_code, 32'h101);
        check("race_flag",  32'(a_timeout_flag), 32'd0);
        a_rsp_ack = 1'b1;
        tick();
        a_rsp_ack = 1'b0;
        check("race_count", 32'(a_cmd_count), 32'd3);

        // Withheld ack with another request pending
        a_req_code[64 +: 32] = 32'h0000_0333;
        a_req_valid = 5'b00100;
        wait_a_start("hold_start");
        check("hold_code", a_exec_code, 32'h333);
        check("hold_loc",  32'(a_exec_locality), 32'd2);
        a_req_code[96 +: 32] = 32'h0000_03A3;
        a_req_valid = 5'b01000;
        tick();
        a_eng_done = 1'b1; a_eng_rc = 32'h33;
        tick();
        a_eng_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_rsp_valid !== 1'b1 || a_grant !== 5'b00000) bad++;
        end
        check("hold_bad_cycles", 32'(bad), 32'd0);
        check("hold_rsp_code", a_rsp_code, 32'h33);
        a_rsp_ack = 1'b1;
        tick();
        a_rsp_ack = 1'b0;
        check("hold_no_early_grant", 32'(a_grant), 32'd0);
        check("hold_count", 32'(a_cmd_count), 32'd4);
        tick();
        check("hold_next_grant", 32'(a_grant), 32'h08);
        check("hold_next_code",  a_exec_code, 32'h3A3);
        a_req_valid = 5'b00000;
        tick();
        a_rsp_ack = 1'b1;
        tick();
        a_rsp_ack = 1'b0;
        a_eng_done = 1'b1; a_eng_rc = 32'h77;
        tick();
        a_eng_done = 1'b0;
        check("exec_ack_ignored", 32'(a_rsp_valid), 32'd1);
        check("exec_ack_code", a_rsp_code, 32'h77);
        a_rsp_ack = 1'b1;
        tick();
        a_rsp_ack = 1'b0;
        check("ack_count", 32'(a_cmd_count), 32'd5);
        a_rsp_ack = 1'b1;
        tick();
        a_rsp_ack = 1'b0;
        tick();
        check("stray_ack_count", 32'(a_cmd_count), 32'd5);
        check("stray_ack_busy",  32'(a_busy), 32'd0);

        // Reset during EXEC
        a_req_code[64 +: 32] = 32'h0000_0444;
        a_req_valid = 5'b00100;
        wait_a_start("rst_mid_start");
        a_req_valid = 5'b00000;
        tick(); tick();
        check("rst_mid_busy_before", 32'(a_busy), 32'd1);
        reset_n = 1'b0;
        tick();
        check("rst_mid_busy",  32'(a_busy), 32'd0);
        check("rst_mid_rsp",   32'(a_rsp_valid), 32'd0);
        check("rst_mid_code",  a_exec_code, 32'd0);
        check("rst_mid_loc",   32'(a_exec_locality), 32'd0);
        check("rst_mid_count", 32'(a_cmd_count), 32'd0);
        reset_n = 1'b1;
        a_eng_done = 1'b1; a_eng_rc = 32'h55;
        tick();
        a_eng_done = 1'b0;
        tick();
        check("rst_no_rsp", 32'(a_rsp_valid), 32'd0);

        // Counter wrap 0xFFFF -> 0
        force u_fp.cmd_count_q = 16'hFFFF;
        tick();
        release u_fp.cmd_count_q;
        check("wrap_preset", 32'(a_cmd_count), 32'hFFFF);
        a_req_code[0 +: 32] = 32'h0000_0001;
        a_req_valid = 5'b00001;
        wait_a_start("wrap_start");
        a_req_valid = 5'b00000;
        tick();
        a_eng_done = 1'b1; a_eng_rc = 32'd0;
        tick();
        a_eng_done = 1'b0;
        a_rsp_ack = 1'b1;
        tick();
        a_rsp_ack = 1'b0;
        check("wrap_count", 32'(a_cmd_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
